// File: rtl/stream_pkg.sv
// Shared stream-steering definitions: port count, select width and the
// select-to-one-hot decode used by both the demux and the 4:1 select mux.
package stream_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned SEL_W     = 2;

  typedef logic [SEL_W-1:0]     sel_t;
  typedef logic [NUM_PORTS-1:0] onehot_t;

  function automatic onehot_t sel_to_onehot(input sel_t sel);
    onehot_t oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux4_stream_if.sv
// Bus bundle for demux4_stream: one upstream valid/ready stream with select,
// four downstream valid bits sharing one data word, plus occupancy.
interface demux4_stream_if
  import stream_pkg::*;
#(
  parameter int unsigned N = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  sel_t          in_sel;
  onehot_t       out_valid;
  onehot_t       out_ready;
  logic [N-1:0]  out_data;
  logic [1:0]    count;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/demux4_stream_fifo2.sv
// Two-entry FIFO with registered pointers and occupancy count.
// When empty, head_data keeps presenting the most recently popped word.
module fifo2 #(
  parameter int unsigned W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != 2'd2);
    do_pop   = pop && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Empty means no push since the last pop, so the slot behind rd_ptr
  // still holds the word last shown at the head.
  always_comb begin
    head_data = (count_q != 2'd0) ? mem_q[rd_ptr_q] : mem_q[~rd_ptr_q];
    count     = count_q;
  end

endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer: buffered words leave in arrival
// order on the port named by their select; in_ready never sees out_ready.
module demux4_stream
  import stream_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic           clk,
  input  logic           rst,
  demux4_stream_if.slave bus
);

  logic [N+1:0] push_word;
  logic [N+1:0] head_word;
  logic [1:0]   count;
  logic         in_ready;
  logic         push;
  logic         pop;
  sel_t         head_sel;
  onehot_t      out_valid;

  always_comb begin
    in_ready  = (count != 2'd2) && !rst;
    push      = bus.in_valid && in_ready;
    push_word = {bus.in_sel, bus.in_data};
    head_sel  = head_word[N+1:N];
    out_valid = (count != 2'd0) ? sel_to_onehot(head_sel) : '0;
    pop       = |(out_valid & bus.out_ready);
  end

  fifo2 #(.W(N + 2)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head_data (head_word),
    .count     (count)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head_word[N-1:0];
  assign bus.count     = count;

endmodule

// File: tb/tb_demux4_stream.sv
// Directed bench for demux4_stream with a queue-based reference of the
// buffered words; checks occur on the falling edge each cycle.
module tb_demux4_stream;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } item_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  item_t q[$];
  logic [31:0] last_data;

  demux4_stream_if #(.N(32)) bus ();

  demux4_stream #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: compare at the falling edge, update the reference for the
  // coming rising edge, then return just after it so inputs can change.
  task automatic tick();
    logic  exp_ready;
    item_t it;
    @(negedge clk);
    if (rst) begin
      check("rst_out_valid", 64'(bus.out_valid), 64'h0);
      check("rst_count", 64'(bus.count), 64'h0);
      check("rst_in_ready", 64'(bus.in_ready), 64'h0);
      check("rst_out_data", 64'(bus.out_data), 64'h0);
      q.delete();
      last_data = '0;
    end else begin
      exp_ready = (q.size() != 2);
      check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
      check("count", 64'(bus.count), 64'(q.size()));
      if (q.size() > 0) begin
        check("out_valid", 64'(bus.out_valid), 64'(4'b0001 << q[0].sel));
        check("out_data", 64'(bus.out_data), 64'(q[0].data));
        if (bus.out_ready[q[0].sel]) begin
          last_data = q[0].data;
          void'(q.pop_front());
        end
      end else begin
        check("empty_out_valid", 64'(bus.out_valid), 64'h0);
        check("empty_out_data", 64'(bus.out_data), 64'(last_data));
      end
      if (bus.in_valid && exp_ready) begin
        it.sel  = bus.in_sel;
        it.data = bus.in_data;
        q.push_back(it);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] data);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = data;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    last_data     = '0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_data   = '0;
    bus.out_ready = '0;

    tick();
    tick();
    rst = 1'b0;

    // single word to port 2
    bus.out_ready = 4'hF;
    drive(1'b1, 2'd2, 32'hDEADBEEF);
    tick();
    drive(1'b0, 2'd0, 32'h0);
    tick();
    tick();
    check("hold_after_pop", 64'(bus.out_data), 64'hDEADBEEF);

    // back-to-back streaming across all ports
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'(i % 4), 32'hA000_0000 + 32'(i));
      tick();
    end
    drive(1'b0, 2'd0, 32'h0);
    tick();
    tick();

    // fill to full under backpressure
    bus.out_ready = 4'b0000;
    drive(1'b1, 2'd1, 32'h11);
    tick();
    drive(1'b1, 2'd3, 32'h22);
    tick();
    drive(1'b1, 2'd0, 32'h33);
    tick();
    tick();
    drive(1'b0, 2'd0, 32'h0);
    bus.out_ready = 4'b0010;
    tick();
    tick();
    bus.out_ready = 4'b1000;
    tick();
    tick();

    // head-of-line blocking on port 0
    bus.out_ready = 4'b1110;
    drive(1'b1, 2'd0, 32'hB0);
    tick();
    drive(1'b1, 2'd1, 32'hB1);
    tick();
    drive(1'b1, 2'd2, 32'hB2);
    tick();
    drive(1'b0, 2'd0, 32'h0);
    tick();
    tick();
    bus.out_ready = 4'hF;
    tick();
    tick();
    tick();

    // push+pop at occupancy 1 with pointer wrap
    drive(1'b1, 2'd3, 32'hC000_0000);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 2'((i * 3) % 4), 32'hC000_0000 + 32'(i));
      tick();
    end
    drive(1'b0, 2'd0, 32'h0);
    tick();
    tick();

    // asynchronous reset while full
    bus.out_ready = 4'b0000;
    drive(1'b1, 2'd1, 32'hD1);
    tick();
    drive(1'b1, 2'd2, 32'hD2);
    tick();
    drive(1'b0, 2'd0, 32'h0);
    tick();
    check("pre_reset_count", 64'(bus.count), 64'h2);
    rst = 1'b1;
    #2;
    check("async_out_valid", 64'(bus.out_valid), 64'h0);
    check("async_count", 64'(bus.count), 64'h0);
    tick();
    rst = 1'b0;
    bus.out_ready = 4'hF;
    tick();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
